apb_arbiter: RTL and testbench

- Two-requester APB bus controller that shares the single APB master port (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB) between the CPU load/store path (port m0) and a secondary requester (port m1, e.g. UART-RX loader or debug).
- Arbitrates with round-robin priority and sequences each transfer through the APB SETUP/ACCESS phases.
- Routes PRDATA and completion back to the winning requester.
- Aborts with an error if PREADY never arrives.

---
 rtl/apb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_apb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// per-requester read-data return and an ACCESS-phase timeout abort.
module apb_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,

    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [1:0]        m0_strb,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [1:0]        m1_strb,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,

    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [1:0]        PSTRB,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,

    output logic [1:0]        grant
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    // Counter value seen on the last ACCESS cycle allowed before abort.
    localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // 0 = m0, 1 = m1
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        strb_q, strb_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic winner;

    // Tie goes to the master that did not win the previous tie.
    always_comb begin
        if (m0_req && m1_req) begin
            winner = ~last_q;
        end else begin
            winner = m1_req;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    owner_d = winner;
                    if (m0_req && m1_req) begin
                        last_d = winner;
                    end
                    addr_d  = winner ? m1_addr  : m0_addr;
                    write_d = winner ? m1_write : m0_write;
                    wdata_d = winner ? m1_wdata : m0_wdata;
                    strb_d  = winner ? m1_strb  : m0_strb;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    err_d = 1'b0;
                    if (!write_q) begin
                        if (owner_q) begin
                            rdata1_d = PRDATA;
                        end else begin
                            rdata0_d = PRDATA;
                        end
                    end
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    err_d = 1'b1;
                    if (!write_q) begin
                        if (owner_q) begin
                            rdata1_d = '0;
                        end else begin
                            rdata0_d = '0;
                        end
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign PSEL    = (state_q == StSetup) || (state_q == StAccess);
    assign PENABLE = (state_q == StAccess);
    assign PADDR   = addr_q;
    assign PWRITE  = write_q;
    assign PWDATA  = wdata_q;
    assign PSTRB   = strb_q;

    assign grant    = (state_q == StIdle) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign m0_done  = (state_q == StResp) && !owner_q;
    assign m1_done  = (state_q == StResp) && owner_q;
    assign m0_err   = m0_done && err_q;
    assign m1_err   = m1_done && err_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Randomised scoreboard bench for apb_arbiter: a transfer-level model predicts
// owner, APB fields, result and completion cycle of every transfer.
module tb_apb_arbiter;

    localparam int unsigned TW = 3;
    localparam int unsigned TO = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        m0_req, m0_write, m0_done, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [1:0]  m0_strb;
    logic        m1_req, m1_write, m1_done, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [1:0]  m1_strb;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [1:0]  PSTRB, grant;

    apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TO_W(TW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_strb(m0_strb), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_strb(m1_strb), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .grant(grant)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          owner;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  strb;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] other_rdata;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Per-requester stimulus and slave behaviour for the current round.
    bit          s_write[2];
    logic [31:0] s_addr[2];
    logic [31:0] s_wdata[2];
    logic [1:0]  s_strb[2];
    int          waits[2];
    logic [31:0] rdv[2];

    // Reference model state.
    bit          m_last = 1'b1;
    logic [31:0] m_rdata[2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic rand_master(int m);
        s_write[m] = 1'($urandom_range(0, 1));
        s_addr[m]  = $urandom & 32'hffff_fffc;
        s_wdata[m] = $urandom;
        s_strb[m]  = 2'($urandom_range(0, 3));
        waits[m]   = $urandom_range(0, 6);
        rdv[m]     = $urandom;
    endtask

    task automatic requester(int m, int n);
        int seen  = 0;
        int guard = 0;
        if (n == 0) return;
        while (seen < n && guard < 200) begin
            @(negedge CLK);
            guard++;
            if ((m == 1) ? m1_done : m0_done) seen++;
        end
        check($sformatf("done_count_m%0d", m), seen, n);
        if (m == 1) m1_req = 1'b0;
        else m0_req = 1'b0;
    endtask

    // Requester m holds req for c[m] completions; the model walks the
    // resulting sequence of transfers and their completion cycles.
    task automatic run(int c0, int c1, bit pulse0);
        int   cnt[2];
        int   t;
        int   a;
        bit   w;
        exp_t e;
        cnt[0] = c0;
        cnt[1] = c1;
        @(posedge CLK);
        #1;
        t = cyc;
        while (cnt[0] > 0 || cnt[1] > 0) begin
            if (cnt[0] > 0 && cnt[1] > 0) begin
                w = ~m_last;
                m_last = w;
            end else begin
                w = (cnt[1] > 0);
            end
            a = (waits[w] >= int'(TO)) ? int'(TO) : waits[w] + 1;
            e.owner = w;
            e.write = s_write[w];
            e.addr  = s_addr[w];
            e.wdata = s_wdata[w];
            e.strb  = s_strb[w];
            e.err   = (waits[w] >= int'(TO));
            if (!s_write[w]) m_rdata[w] = e.err ? 32'h0 : rdv[w];
            e.rdata       = m_rdata[w];
            e.other_rdata = m_rdata[~w];
            e.done_cyc    = t + 2 + a;
            sb.push_back(e);
            t = e.done_cyc + 1;
            cnt[w]--;
        end
        m0_write = s_write[0]; m0_addr = s_addr[0]; m0_wdata = s_wdata[0]; m0_strb = s_strb[0];
        m1_write = s_write[1]; m1_addr = s_addr[1]; m1_wdata = s_wdata[1]; m1_strb = s_strb[1];
        m0_req = (c0 > 0);
        m1_req = (c1 > 0);
        fork
            requester(0, c0);
            requester(1, c1);
            if (pulse0) begin
                repeat (3) @(posedge CLK);
                #1 m0_req = 1'b1;
                @(posedge CLK);
                #1 m0_req = 1'b0;
            end
        join
    endtask

    // APB slave: PREADY after waits[owner] wait states, returning rdv[owner].
    initial begin
        int acc = 0;
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (PSEL && PENABLE) begin
                PREADY = (acc >= waits[grant[1]]);
                PRDATA = rdv[grant[1]];
                acc++;
            end else begin
                acc    = 0;
                PREADY = 1'b0;
                PRDATA = $urandom;
            end
        end
    end

    // Monitor: tracks APB fields from SETUP, checks them at each completion.
    initial begin
        logic [31:0] c_addr, c_wdata;
        logic        c_write;
        logic [1:0]  c_strb;
        bit          unstable;
        c_addr = '0; c_wdata = '0; c_write = 1'b0; c_strb = '0; unstable = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                if (PSEL && !PENABLE) begin
                    c_addr = PADDR; c_wdata = PWDATA; c_write = PWRITE; c_strb = PSTRB;
                    unstable = 1'b0;
                end else if (PSEL && PENABLE) begin
                    if (PADDR !== c_addr || PWDATA !== c_wdata || PWRITE !== c_write ||
                        PSTRB !== c_strb) unstable = 1'b1;
                end
                if (m0_done || m1_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", {30'b0, m1_done, m0_done}, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("done_owner", {30'b0, m1_done, m0_done}, e.owner ? 32'd2 : 32'd1);
                        check("done_cycle", cyc, e.done_cyc);
                        check("grant", {30'b0, grant}, e.owner ? 32'd2 : 32'd1);
                        check("err", {31'b0, e.owner ? m1_err : m0_err}, {31'b0, e.err});
                        check("rdata", e.owner ? m1_rdata : m0_rdata, e.rdata);
                        check("other_rdata", e.owner ? m0_rdata : m1_rdata, e.other_rdata);
                        check("paddr", c_addr, e.addr);
                        check("pwrite", {31'b0, c_write}, {31'b0, e.write});
                        check("pwdata", c_wdata, e.wdata);
                        check("pstrb", {30'b0, c_strb}, {30'b0, e.strb});
                        check("apb_stable", {31'b0, unstable}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int guard;
        m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0; m0_strb = '0;
        m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0; m1_strb = '0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        rand_master(0);
        rand_master(1);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_psel", {31'b0, PSEL}, 32'd0);
        check("rst_penable", {31'b0, PENABLE}, 32'd0);
        check("rst_grant", {30'b0, grant}, 32'd0);
        check("rst_done", {30'b0, m1_done, m0_done}, 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b1;

        // Zero-wait write from m0.
        s_write[0] = 1'b1; s_addr[0] = 32'h4; s_wdata[0] = 32'ha5; s_strb[0] = 2'b11;
        waits[0] = 0;
        run(1, 0, 1'b0);

        // Both held for two transfers each: strict alternation starting with m0.
        rand_master(0); rand_master(1);
        waits[0] = 0; waits[1] = 0;
        run(2, 2, 1'b0);

        // m1 read with three wait states.
        rand_master(1);
        s_write[1] = 1'b0; s_addr[1] = 32'h8; waits[1] = 3; rdv[1] = 32'h1234_5678;
        run(0, 1, 1'b0);

        // Async reset in the middle of ACCESS.
        rand_master(0);
        s_write[0] = 1'b0; waits[0] = 100;
        @(posedge CLK);
        #1;
        m0_write = s_write[0]; m0_addr = s_addr[0]; m0_wdata = s_wdata[0]; m0_strb = s_strb[0];
        m0_req = 1'b1;
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (!PENABLE && guard < 10);
        check("reach_access", {31'b0, PENABLE}, 32'd1);
        #2 RESET = 1'b0;
        #1;
        check("arst_psel", {31'b0, PSEL}, 32'd0);
        check("arst_penable", {31'b0, PENABLE}, 32'd0);
        check("arst_grant", {30'b0, grant}, 32'd0);
        check("arst_done", {30'b0, m1_done, m0_done}, 32'd0);
        check("arst_rdata", m0_rdata | m1_rdata, 32'd0);
        m0_req = 1'b0;
        sb.delete();
        m_last = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        @(posedge CLK);
        #1 RESET = 1'b1;

        // Tie right after reset: m0 first, its read times out, then m1 is served.
        rand_master(0); rand_master(1);
        s_write[0] = 1'b0; waits[0] = 6;
        run(1, 1, 1'b0);

        // Timeout boundary: last allowed wait state completes normally.
        rand_master(0);
        s_write[0] = 1'b0; waits[0] = TO - 1;
        run(1, 0, 1'b0);

        // One-cycle m0 pulse during an m1 transfer must not produce a transfer.
        rand_master(0); rand_master(1);
        waits[1] = $urandom_range(2, 6);
        run(0, 1, 1'b1);
        repeat (10) @(posedge CLK);

        for (int i = 0; i < 60; i++) begin
            rand_master(0);
            rand_master(1);
            c0 = $urandom_range(0, 2);
            c1 = $urandom_range(0, 2);
            if (c0 == 0 && c1 == 0) c0 = 1;
            run(c0, c1, 1'b0);
        end

        repeat (5) @(posedge CLK);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
